// File: rtl/wave_pkg.sv
// Shared constants, coordinate bundle and helpers for the waveform display pipeline.
package wave_pkg;

    localparam logic [10:0] WIN_X_MIN  = 11'd128;
    localparam logic [10:0] WIN_X_MAX  = 11'd639;
    localparam logic [9:0]  WIN_Y_MIN  = 10'd112;
    localparam logic [9:0]  WIN_Y_MAX  = 10'd367;
    localparam logic [9:0]  IDLE_Y_MIN = 10'd368;
    localparam logic [8:0]  X_OFS      = 9'd128;
    localparam logic [7:0]  Y_OFS      = 8'd112;
    localparam logic [7:0]  AXIS_ROW   = 8'd128;
    localparam logic [7:0]  COLOR_LIT  = 8'hFF;
    localparam logic [7:0]  COLOR_AXIS = 8'h40;
    localparam logic [7:0]  COLOR_OFF  = 8'h00;
    localparam int          PIPE_DEPTH = 2;

    typedef struct packed {
        logic       valid;
        logic [9:0] y;
        logic [10:0] x;
    } coord_t;

    function automatic logic in_window(input logic [10:0] px, input logic [9:0] py);
        return (px >= WIN_X_MIN) && (px <= WIN_X_MAX) && (py >= WIN_Y_MIN) && (py <= WIN_Y_MAX);
    endfunction

    // Larger samples plot nearer the top of the window.
    function automatic logic [7:0] plot_row(input logic [7:0] sample);
        return 8'd255 - sample;
    endfunction

endpackage

// File: rtl/pipe_reg.sv
// Fixed-depth delay line with asynchronous active-low clear.
module pipe_reg #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    // Shift register: stage 0 takes d, later stages take their predecessor.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/wave_display_pipe.sv
// Draws the captured waveform into the VGA window: fetches samples, joins
// consecutive samples with vertical strokes, and emits pixel colours two cycles later.
module wave_display_pipe
    import wave_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] x,
    input  logic [9:0]  y,
    input  logic        valid,
    input  logic        read_index,
    output logic [8:0]  read_address,
    input  logic [7:0]  read_value,
    output logic        valid_pixel,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic        wave_display_idle
);

    coord_t      in_s, s1_s, s2_s;
    logic        in_win_s, s1_in_win_s, s2_in_win_s;
    logic [8:0]  x_rel_s, s1_x_rel_s;
    logic [7:0]  s1_y_rel_s, s2_y_rel_s;
    logic [8:0]  addr_q, addr_s;
    logic        display_half_q;
    logic [7:0]  prev_q, cur_q, prev_d, cur_d;
    logic [7:0]  row_lo_s, row_hi_s;
    logic        new_sample_s, left_edge_s, lit_d, lit_q, idle_q;

    assign in_s = '{valid: valid, y: y, x: x};

    pipe_reg #(.WIDTH($bits(coord_t)), .DEPTH(1)) u_stage1 (
        .clk (clk), .rst (rst), .d (in_s), .q (s1_s)
    );
    pipe_reg #(.WIDTH($bits(coord_t)), .DEPTH(PIPE_DEPTH - 1)) u_stage2 (
        .clk (clk), .rst (rst), .d (s1_s), .q (s2_s)
    );

    assign in_win_s = valid && in_window(x, y);
    assign x_rel_s  = x[8:0] - X_OFS;
    assign addr_s   = {display_half_q, x_rel_s[8:1]};

    // Address follows x inside the window, otherwise repeats the last fetch.
    always_comb begin
        read_address = addr_q;
        if (rst && in_win_s) begin
            read_address = addr_s;
        end else begin
            read_address = addr_q;
        end
    end

    // Half select is sampled only at frame start so a frame never mixes buffers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q         <= 9'd0;
            display_half_q <= 1'b0;
            idle_q         <= 1'b0;
        end else begin
            addr_q         <= in_win_s ? addr_s : addr_q;
            display_half_q <= (valid && (x == 11'd0) && (y == 10'd0)) ? ~read_index : display_half_q;
            idle_q         <= (y >= IDLE_Y_MIN);
        end
    end

    assign s1_in_win_s  = s1_s.valid && in_window(s1_s.x, s1_s.y);
    assign s1_x_rel_s   = s1_s.x[8:0] - X_OFS;
    assign s1_y_rel_s   = s1_s.y[7:0] - Y_OFS;
    assign new_sample_s = s1_in_win_s && !s1_x_rel_s[0];
    assign left_edge_s  = s1_in_win_s && (s1_x_rel_s == 9'd0);

    // Stage 1: the fresh RAM word becomes current; at the left edge the stroke collapses to a point.
    always_comb begin
        cur_d  = new_sample_s ? read_value : cur_q;
        prev_d = prev_q;
        if (left_edge_s) begin
            prev_d = read_value;
        end else if (new_sample_s) begin
            prev_d = cur_q;
        end else begin
            prev_d = prev_q;
        end
        if (plot_row(prev_d) <= plot_row(cur_d)) begin
            row_lo_s = plot_row(prev_d);
            row_hi_s = plot_row(cur_d);
        end else begin
            row_lo_s = plot_row(cur_d);
            row_hi_s = plot_row(prev_d);
        end
        lit_d = s1_in_win_s && (s1_y_rel_s >= row_lo_s) && (s1_y_rel_s <= row_hi_s);
    end

    // Sample history and the lit decision advance into stage 2.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q <= 8'd0;
            cur_q  <= 8'd0;
            lit_q  <= 1'b0;
        end else begin
            prev_q <= prev_d;
            cur_q  <= cur_d;
            lit_q  <= lit_d;
        end
    end

    assign s2_in_win_s       = in_window(s2_s.x, s2_s.y);
    assign s2_y_rel_s        = s2_s.y[7:0] - Y_OFS;
    assign valid_pixel       = s2_s.valid;
    assign wave_display_idle = idle_q;

    // Stage 2 colour decode from registered state only.
    always_comb begin
        r = COLOR_OFF;
        g = COLOR_OFF;
        b = COLOR_OFF;
        if (!s2_s.valid || !s2_in_win_s) begin
            g = COLOR_OFF;
        end else if (lit_q) begin
            r = COLOR_LIT;
            g = COLOR_LIT;
            b = COLOR_LIT;
        end else if (s2_y_rel_s == AXIS_ROW) begin
            g = COLOR_AXIS;
        end else begin
            g = COLOR_OFF;
        end
    end

endmodule

// File: tb/tb_wave_display_pipe.sv
// Directed bench for wave_display_pipe with a one-cycle-latency sample RAM model.
module tb_wave_display_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [10:0] x = 11'd0;
    logic [9:0]  y = 10'd0;
    logic        valid = 1'b0;
    logic        read_index = 1'b0;
    logic [8:0]  read_address;
    logic [7:0]  read_value = 8'd0;
    logic        valid_pixel;
    logic [7:0]  r, g, b;
    logic        wave_display_idle;
    logic [7:0]  mem [512];
    int          n_checks = 0;
    int          n_errors = 0;

    wave_display_pipe dut (
        .clk               (clk),
        .rst               (rst),
        .x                 (x),
        .y                 (y),
        .valid             (valid),
        .read_index        (read_index),
        .read_address      (read_address),
        .read_value        (read_value),
        .valid_pixel       (valid_pixel),
        .r                 (r),
        .g                 (g),
        .b                 (b),
        .wave_display_idle (wave_display_idle)
    );

    always #5 clk = ~clk;

    always @(posedge clk) read_value <= mem[read_address];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [10:0] px, input logic [9:0] py, input logic pv);
        x     = px;
        y     = py;
        valid = pv;
    endtask

    // Streams x0..x1 on row py; afterwards the outputs show pixel x1.
    task automatic run_row(input logic [9:0] py, input int x0, input int x1);
        for (int i = x0; i <= x1; i++) begin
            drive(11'(i), py, 1'b1);
            cyc();
        end
        drive(11'd700, py, 1'b0);
        cyc();
    endtask

    task automatic fill_mem(input logic [7:0] v);
        for (int i = 0; i < 512; i++) mem[i] = v;
    endtask

    task automatic check_rgb(input string tag, input logic [23:0] exp);
        check_eq(tag, 32'({r, g, b}), 32'(exp));
    endtask

    initial begin
        fill_mem(8'd128);
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_valid_pixel", 32'(valid_pixel), 32'd0);
        check_rgb("rst_rgb", 24'h000000);
        check_eq("rst_idle", 32'(wave_display_idle), 32'd0);
        check_eq("rst_addr", 32'(read_address), 32'd0);
        rst = 1'b1;
        cyc();

        // Frame start with read_index=0 selects half 1.
        read_index = 1'b0;
        drive(11'd0, 10'd0, 1'b1);
        cyc();
        drive(11'd130, 10'd200, 1'b1); #1;
        check_eq("addr_x130", 32'(read_address), 32'h101);
        drive(11'd131, 10'd200, 1'b1); #1;
        check_eq("addr_x131", 32'(read_address), 32'h101);
        drive(11'd132, 10'd200, 1'b1); #1;
        check_eq("addr_x132", 32'(read_address), 32'h102);
        cyc();
        drive(11'd700, 10'd200, 1'b1); #1;
        check_eq("addr_hold", 32'(read_address), 32'h102);
        cyc();

        // Constant mid-scale samples: flat line on row 127, axis on row 128.
        run_row(10'd239, 296, 300);
        check_eq("flat_valid", 32'(valid_pixel), 32'd1);
        check_rgb("flat_lit", 24'hFFFFFF);
        run_row(10'd238, 296, 300);
        check_rgb("flat_above", 24'h000000);
        run_row(10'd240, 296, 300);
        check_rgb("flat_axis", 24'h004000);
        run_row(10'd367, 296, 300);
        check_rgb("flat_bottom", 24'h000000);
        run_row(10'd111, 296, 300);
        check_eq("above_win_valid", 32'(valid_pixel), 32'd1);
        check_rgb("above_win", 24'h000000);
        run_row(10'd239, 636, 639);
        check_rgb("right_edge_lit", 24'hFFFFFF);
        run_row(10'd239, 636, 640);
        check_rgb("x640_outside", 24'h000000);
        run_row(10'd239, 128, 128);
        check_rgb("left_edge_lit", 24'hFFFFFF);
        run_row(10'd240, 126, 127);
        check_rgb("x127_outside", 24'h000000);

        // valid=0 forces black; a lit pixel appears exactly two cycles after input.
        drive(11'd300, 10'd239, 1'b0);
        cyc(); cyc();
        check_eq("invalid_vp", 32'(valid_pixel), 32'd0);
        check_rgb("invalid_rgb", 24'h000000);
        drive(11'd300, 10'd239, 1'b1);
        cyc();
        check_rgb("latency_1cyc", 24'h000000);
        drive(11'd700, 10'd239, 1'b0);
        cyc();
        check_rgb("latency_2cyc", 24'hFFFFFF);

        // Stroke from sample 0 to 255 fills the whole column.
        fill_mem(8'd0);
        mem[9'h125] = 8'd255;
        run_row(10'd200, 198, 200);
        check_rgb("zero_sample_row", 24'h000000);
        for (int yy = 112; yy <= 367; yy++) begin
            run_row(10'(yy), 198, 202);
            check_rgb("line_fill", 24'hFFFFFF);
        end

        // Buffer select changes only at frame start.
        drive(11'd130, 10'd200, 1'b1);
        read_index = 1'b1; #1;
        check_eq("latch_hold_a", 32'(read_address), 32'h101);
        cyc();
        drive(11'd132, 10'd300, 1'b1); #1;
        check_eq("latch_hold_b", 32'(read_address), 32'h102);
        cyc();
        drive(11'd0, 10'd0, 1'b0);
        cyc();
        drive(11'd130, 10'd200, 1'b1); #1;
        check_eq("latch_needs_valid", 32'(read_address), 32'h101);
        cyc();
        drive(11'd0, 10'd0, 1'b1);
        cyc();
        drive(11'd130, 10'd200, 1'b1); #1;
        check_eq("latch_new_frame", 32'(read_address), 32'h001);
        cyc();
        drive(11'd0, 10'd0, 1'b1);
        read_index = 1'b0;
        cyc();
        drive(11'd130, 10'd200, 1'b1); #1;
        check_eq("latch_coincident", 32'(read_address), 32'h101);
        cyc();

        // Idle flag tracks y>=368 one cycle late.
        drive(11'd300, 10'd367, 1'b1);
        cyc();
        check_eq("idle_y367", 32'(wave_display_idle), 32'd0);
        drive(11'd300, 10'd368, 1'b1); #1;
        check_eq("idle_before_edge", 32'(wave_display_idle), 32'd0);
        cyc();
        check_eq("idle_y368", 32'(wave_display_idle), 32'd1);
        drive(11'd300, 10'd0, 1'b1); #1;
        check_eq("idle_hold", 32'(wave_display_idle), 32'd1);
        cyc();
        check_eq("idle_y0", 32'(wave_display_idle), 32'd0);
        drive(11'd0, 10'd500, 1'b0);
        cyc();
        check_eq("idle_invalid", 32'(wave_display_idle), 32'd1);

        // Asynchronous reset mid-frame.
        fill_mem(8'd128);
        drive(11'd300, 10'd239, 1'b1);
        cyc();
        drive(11'd300, 10'd400, 1'b1);
        cyc();
        check_eq("pre_rst_vp", 32'(valid_pixel), 32'd1);
        drive(11'd300, 10'd239, 1'b1);
        #2 rst = 1'b0;
        #1;
        check_eq("mid_rst_vp", 32'(valid_pixel), 32'd0);
        check_rgb("mid_rst_rgb", 24'h000000);
        check_eq("mid_rst_idle", 32'(wave_display_idle), 32'd0);
        check_eq("mid_rst_addr", 32'(read_address), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_eq("post_rst_addr", 32'(read_address), 32'h056);
        cyc();
        drive(11'd700, 10'd239, 1'b0);
        cyc();
        check_rgb("post_rst_stroke", 24'hFFFFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
